// File: rtl/pe_fpga_top.sv
// UART loopback demo top: periodic 8N1 transmitter with an incrementing byte,
// oversampled receiver, hex/LED display of the last received byte and a 1 Hz divider.
`timescale 1ns/1ps
module pe_fpga_top #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int TX_GAP   = 10000
) (
  input  logic       clk,
  input  logic [1:0] key,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [9:0] ledr,
  input  logic       iRx_serial,
  output logic       oTx_Serial,
  output logic       clk_1hz,
  output logic       xor_tot,
  output logic       xor_tot2
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int HALF_HZ      = CLK_FREQ / 2;
  localparam int BW           = $clog2(CLKS_PER_BIT + 1);
  localparam int HW           = $clog2(HALF_HZ + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_BIT - 1);
  localparam logic [HW-1:0] HZ_LAST   = HW'(HALF_HZ - 1);
  localparam logic [31:0]   GAP_LEN   = 32'(TX_GAP);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;

  logic       rst;
  logic       unusedKey;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rx_ready;
  logic [7:0] rx_data;

  assign rst       = ~key[0];
  assign unusedKey = key[1];

  logic [HW-1:0] hzCnt_q;
  logic          clk1hz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hzCnt_q  <= '0;
      clk1hz_q <= 1'b0;
    end else if (hzCnt_q == HZ_LAST) begin
      hzCnt_q  <= '0;
      clk1hz_q <= ~clk1hz_q;
    end else begin
      hzCnt_q  <= hzCnt_q + 1'b1;
    end
  end

  txState_e      txState_q, txState_d;
  logic [BW-1:0] txCnt_q, txCnt_d;
  logic [2:0]    txBit_q, txBit_d;
  logic [7:0]    txShift_q, txShift_d;
  logic [7:0]    txByte_q, txByte_d;
  logic [31:0]   gapCnt_q, gapCnt_d;
  logic          txStart_q, txStart_d;
  logic          txLine_q, txLine_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txByte_q  <= '0;
      gapCnt_q  <= '0;
      txStart_q <= 1'b0;
      txLine_q  <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txByte_q  <= txByte_d;
      gapCnt_q  <= gapCnt_d;
      txStart_q <= txStart_d;
      txLine_q  <= txLine_d;
    end
  end

  // The idle gap is measured from reset release or the end of the stop bit.
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txByte_d  = txByte_q;
    gapCnt_d  = gapCnt_q;
    txStart_d = 1'b0;
    txLine_d  = txLine_q;
    case (txState_q)
      TX_IDLE: begin
        txLine_d = 1'b1;
        if (txStart_q) begin
          txState_d = TX_START;
          txCnt_d   = '0;
          txLine_d  = 1'b0;
        end else if (gapCnt_q == GAP_LEN) begin
          txStart_d = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q + 32'd1;
        end
      end
      TX_START: begin
        if (txCnt_q == BIT_LAST) begin
          txState_d = TX_DATA;
          txCnt_d   = '0;
          txBit_d   = '0;
          txLine_d  = txByte_q[0];
          txShift_d = {1'b0, txByte_q[7:1]};
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (txCnt_q == BIT_LAST) begin
          txCnt_d = '0;
          if (txBit_q == 3'd7) begin
            txState_d = TX_STOP;
            txLine_d  = 1'b1;
          end else begin
            txBit_d   = txBit_q + 3'd1;
            txLine_d  = txShift_q[0];
            txShift_d = {1'b0, txShift_q[7:1]};
          end
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (txCnt_q == BIT_LAST) begin
          txState_d = TX_IDLE;
          txCnt_d   = '0;
          gapCnt_d  = 32'd1;
          txByte_d  = txByte_q + 8'd1;
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  logic rxSync1_q, rxSync2_q, rxPrev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
    end else begin
      rxSync1_q <= iRx_serial;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
    end
  end

  rxState_e      rxState_q, rxState_d;
  logic [BW-1:0] rxCnt_q, rxCnt_d;
  logic [2:0]    rxBit_q, rxBit_d;
  logic [7:0]    rxShift_q, rxShift_d;
  logic [7:0]    rxData_q, rxData_d;
  logic          rxReady_q, rxReady_d;
  logic          frameErr_q, frameErr_d;
  logic          errWait_q, errWait_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxState_q  <= RX_IDLE;
      rxCnt_q    <= '0;
      rxBit_q    <= '0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      rxReady_q  <= 1'b0;
      frameErr_q <= 1'b0;
      errWait_q  <= 1'b0;
    end else begin
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      rxBit_q    <= rxBit_d;
      rxShift_q  <= rxShift_d;
      rxData_q   <= rxData_d;
      rxReady_q  <= rxReady_d;
      frameErr_q <= frameErr_d;
      errWait_q  <= errWait_d;
    end
  end

  // After a bad stop bit the receiver parks in STOP until the line is high again.
  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q;
    rxBit_d    = rxBit_q;
    rxShift_d  = rxShift_q;
    rxData_d   = rxData_q;
    rxReady_d  = 1'b0;
    frameErr_d = frameErr_q;
    errWait_d  = errWait_q;
    case (rxState_q)
      RX_IDLE: begin
        errWait_d = 1'b0;
        if (rxPrev_q && !rxSync2_q) begin
          rxState_d = RX_START;
          rxCnt_d   = '0;
        end
      end
      RX_START: begin
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d = '0;
          rxBit_d = '0;
          rxState_d = rxSync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d   = '0;
          rxShift_d = {rxSync2_q, rxShift_q[7:1]};
          if (rxBit_q == 3'd7) begin
            rxState_d = RX_STOP;
          end else begin
            rxBit_d = rxBit_q + 3'd1;
          end
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (errWait_q) begin
          if (rxSync2_q) begin
            rxState_d = RX_IDLE;
            errWait_d = 1'b0;
          end
        end else if (rxCnt_q == BIT_LAST) begin
          rxCnt_d = '0;
          if (rxSync2_q) begin
            rxData_d  = rxShift_q;
            rxReady_d = 1'b1;
            rxState_d = RX_IDLE;
          end else begin
            frameErr_d = 1'b1;
            errWait_d  = 1'b1;
          end
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  function automatic logic [7:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: hexSeg = 8'hC0;
      4'h1: hexSeg = 8'hF9;
      4'h2: hexSeg = 8'hA4;
      4'h3: hexSeg = 8'hB0;
      4'h4: hexSeg = 8'h99;
      4'h5: hexSeg = 8'h92;
      4'h6: hexSeg = 8'h82;
      4'h7: hexSeg = 8'hF8;
      4'h8: hexSeg = 8'h80;
      4'h9: hexSeg = 8'h90;
      4'hA: hexSeg = 8'h88;
      4'hB: hexSeg = 8'h83;
      4'hC: hexSeg = 8'hC6;
      4'hD: hexSeg = 8'hA1;
      4'hE: hexSeg = 8'h86;
      default: hexSeg = 8'h8E;
    endcase
  endfunction

  assign tx_start   = txStart_q;
  assign tx_data    = txByte_q;
  assign rx_ready   = rxReady_q;
  assign rx_data    = rxData_q;
  assign oTx_Serial = txLine_q;
  assign clk_1hz    = clk1hz_q;
  assign xor_tot    = ^rx_data;
  assign xor_tot2   = ^tx_data;
  assign ledr       = {clk1hz_q, frameErr_q, rxData_q};
  assign HEX0       = hexSeg(rx_data[3:0]);
  assign HEX1       = hexSeg(rx_data[7:4]);

endmodule

// File: tb/tb_pe_fpga_top.sv
// Directed bench for pe_fpga_top with scaled-down clock/baud so a run stays short.
`timescale 1ns/1ps
module tb_pe_fpga_top;

  localparam int CLK_FREQ = 20000;
  localparam int BAUD     = 500;
  localparam int TX_GAP   = 200;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF_HZ  = CLK_FREQ / 2;
  localparam int LAT_MAX  = 10 * CPB + 4;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [7:0] HEX0, HEX1;
  logic [9:0] ledr;
  logic       iRx_serial, oTx_Serial, clk_1hz, xor_tot, xor_tot2;
  logic       rxForce, rxDrive;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cycBase = 0;
  int rxPulses = 0;

  pe_fpga_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TX_GAP(TX_GAP)) dut (
    .clk(clk), .key(key), .HEX0(HEX0), .HEX1(HEX1), .ledr(ledr),
    .iRx_serial(iRx_serial), .oTx_Serial(oTx_Serial), .clk_1hz(clk_1hz),
    .xor_tot(xor_tot), .xor_tot2(xor_tot2)
  );

  // Loopback unless the bench takes over the RX line.
  assign iRx_serial = rxForce ? rxDrive : oTx_Serial;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic holdRx(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (dut.rx_ready) rxPulses++;
      rxDrive = v;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    holdRx(1'b0, CPB);
    for (int b = 0; b < 8; b++) holdRx(data[b], CPB);
    holdRx(stopBit, CPB);
    holdRx(1'b1, 2 * CPB);
  endtask

  task automatic waitRel(input int n);
    while (cyc - cycBase < n) begin
      @(negedge clk);
      if (dut.rx_ready) rxPulses++;
    end
  endtask

  task automatic waitRx(input int maxCyc, output int lat);
    lat = -1;
    for (int k = 1; k <= maxCyc; k++) begin
      @(negedge clk);
      if (dut.rx_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic waitTxLow(input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxCyc; k++) begin
      if (oTx_Serial === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitTxStart(input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxCyc; k++) begin
      @(negedge clk);
      if (dut.tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int lat;
    logic [7:0] ib;

    key = 2'b10;
    rxForce = 1'b0;
    rxDrive = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rstTx", oTx_Serial, 1);
    checkOutput("rstTxStart", dut.tx_start, 0);
    checkOutput("rstTxData", dut.tx_data, 8'h00);
    checkOutput("rstRxReady", dut.rx_ready, 0);
    checkOutput("rstRxData", dut.rx_data, 8'h00);
    checkOutput("rstLedr", ledr, 10'h000);
    checkOutput("rstHex0", HEX0, 8'hC0);
    checkOutput("rstHex1", HEX1, 8'hC0);
    checkOutput("rstClk1hz", clk_1hz, 0);
    checkOutput("rstXor", {xor_tot, xor_tot2}, 2'b00);

    key = 2'b11;
    cycBase = cyc;
    waitRel(TX_GAP);
    checkOutput("startEarly", dut.tx_start, 0);
    waitRel(TX_GAP + 1);
    checkOutput("firstStart", dut.tx_start, 1);
    checkOutput("firstData", dut.tx_data, 8'h00);
    checkOutput("lineIdleAtStart", oTx_Serial, 1);
    waitRel(TX_GAP + 2);
    checkOutput("startBitLow", oTx_Serial, 0);
    checkOutput("startPulseOnce", dut.tx_start, 0);

    for (int i = 0; i < 8; i++) begin
      ib = 8'(i);
      waitTxLow(1000, ok);
      checkOutput("txFrameSeen", ok, 1);
      waitRx(LAT_MAX + 20, lat);
      checkOutput("rxSeen", lat > 0, 1);
      checkOutput("rxLatency", (lat > 0 && lat <= LAT_MAX), 1);
      checkOutput("loopRxData", dut.rx_data, ib);
      checkOutput("loopLedr", ledr[7:0], ib);
      checkOutput("loopTxData", dut.tx_data, ib);
      checkOutput("loopXorRx", xor_tot, ^ib);
      checkOutput("loopXorTx", xor_tot2, ^ib);
      checkOutput("loopNoFerr", ledr[8], 0);
      @(negedge clk);
      checkOutput("rxReadyOneCycle", dut.rx_ready, 0);
    end

    rxDrive = 1'b1;
    rxForce = 1'b1;
    holdRx(1'b1, 20);

    rxPulses = 0;
    applyStimulus(8'h3A, 1'b1);
    checkOutput("frame3aPulses", rxPulses, 1);
    checkOutput("frame3aData", dut.rx_data, 8'h3A);
    checkOutput("frame3aHex1", HEX1, 8'hB0);
    checkOutput("frame3aHex0", HEX0, 8'h88);
    checkOutput("frame3aLedr", ledr[7:0], 8'h3A);
    checkOutput("frame3aXor", xor_tot, 0);

    rxPulses = 0;
    applyStimulus(8'h55, 1'b0);
    checkOutput("badStopPulses", rxPulses, 0);
    checkOutput("badStopFerr", ledr[8], 1);
    checkOutput("badStopKeep", dut.rx_data, 8'h3A);

    rxPulses = 0;
    applyStimulus(8'hC4, 1'b1);
    checkOutput("afterErrPulses", rxPulses, 1);
    checkOutput("afterErrData", dut.rx_data, 8'hC4);
    checkOutput("afterErrHex1", HEX1, 8'hC6);
    checkOutput("afterErrHex0", HEX0, 8'h99);
    checkOutput("afterErrXor", xor_tot, 1);
    checkOutput("ferrSticky", ledr[8], 1);

    rxPulses = 0;
    holdRx(1'b0, 10);
    holdRx(1'b1, 200);
    checkOutput("glitchPulses", rxPulses, 0);
    applyStimulus(8'h81, 1'b1);
    checkOutput("postGlitchPulses", rxPulses, 1);
    checkOutput("postGlitchData", dut.rx_data, 8'h81);
    checkOutput("postGlitchHex1", HEX1, 8'h80);
    checkOutput("postGlitchHex0", HEX0, 8'hF9);

    waitTxStart(1000, ok);
    checkOutput("txStartSeen", ok, 1);
    rxForce = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("midFrameTxData", dut.tx_data != 8'h00, 1);
    key = 2'b10;
    @(negedge clk);
    checkOutput("midRstLine", oTx_Serial, 1);
    checkOutput("midRstTxData", dut.tx_data, 8'h00);
    checkOutput("midRstTxStart", dut.tx_start, 0);
    checkOutput("midRstLedr", ledr, 10'h000);
    checkOutput("midRstHex0", HEX0, 8'hC0);
    key = 2'b11;
    cycBase = cyc;
    rxPulses = 0;
    waitRel(TX_GAP);
    checkOutput("reStartEarly", dut.tx_start, 0);
    waitRel(TX_GAP + 1);
    checkOutput("reStart", dut.tx_start, 1);
    checkOutput("reStartData", dut.tx_data, 8'h00);
    checkOutput("noPartialByte", rxPulses, 0);
    waitRx(LAT_MAX + 20, lat);
    checkOutput("reRxSeen", lat > 0, 1);
    checkOutput("reRxData", dut.rx_data, 8'h00);

    waitRel(HALF_HZ - 1);
    checkOutput("hzBeforeToggle", clk_1hz, 0);
    waitRel(HALF_HZ);
    checkOutput("hzToggleHigh", clk_1hz, 1);
    checkOutput("hzLedr9", ledr[9], 1);
    waitRel(2 * HALF_HZ);
    checkOutput("hzToggleLow", clk_1hz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
